// File: rtl/controle_maxmin_pkg.sv
// Shared constants for the frame max/min controller: widths, default frame size
// and FSM state codes.
package controle_maxmin_pkg;

   localparam int unsigned W_DADO            = 8;
   localparam int unsigned W_CONT            = 8;
   localparam int unsigned W_ESTADO          = 3;
   localparam int unsigned N_AMOSTRAS_PADRAO = 8;

   typedef enum logic [W_ESTADO-1:0] {
      INICIAL     = 3'd0,
      PRIMEIRO    = 3'd1,
      ESPERA_DADO = 3'd2,
      COMPARA_MAX = 3'd3,
      COMPARA_MIN = 3'd4,
      FIM         = 3'd5
   } estado_t;

endpackage

// File: rtl/controle_maxmin_if.sv
// Sample handshake plus result/status bundle of controle_maxmin.
interface controle_maxmin_if;
   import controle_maxmin_pkg::*;

   logic                iniciar;
   logic [W_DADO-1:0]   dado;
   logic                dado_valido;
   logic                dado_pronto;
   logic [W_DADO-1:0]   maximo;
   logic [W_DADO-1:0]   minimo;
   logic [W_CONT-1:0]   contagem;
   logic                ocupado;
   logic                fim;
   logic [W_ESTADO-1:0] db_estado;

   modport slave (
      input  iniciar, dado, dado_valido,
      output dado_pronto, maximo, minimo, contagem, ocupado, fim, db_estado
   );

   modport master (
      output iniciar, dado, dado_valido,
      input  dado_pronto, maximo, minimo, contagem, ocupado, fim, db_estado
   );

endinterface

// File: rtl/comparador_8bit.sv
// Unsigned magnitude comparator; strict greater/less flags of a against b.
module comparador_8bit
   import controle_maxmin_pkg::*;
(
   input  logic [W_DADO-1:0] a_i,
   input  logic [W_DADO-1:0] b_i,
   output logic              maior_o,
   output logic              menor_o
);

   assign maior_o = (a_i > b_i);
   assign menor_o = (a_i < b_i);

endmodule

// File: rtl/controle_maxmin.sv
// Frame controller: accepts N_AMOSTRAS samples and tracks running max/min using a
// single comparator shared between a max phase and a min phase.
module controle_maxmin
   import controle_maxmin_pkg::*;
#(
   parameter int unsigned N_AMOSTRAS = N_AMOSTRAS_PADRAO
)(
   input  logic              clock,
   input  logic              reset,
   controle_maxmin_if.slave  bus
);

   estado_t           estado_q, estado_d;
   logic [W_DADO-1:0] maximo_q, maximo_d;
   logic [W_DADO-1:0] minimo_q, minimo_d;
   logic [W_DADO-1:0] amostra_q, amostra_d;
   logic [W_CONT-1:0] contagem_q, contagem_d;
   logic              pronto_q, pronto_d;
   logic              ocupado_q, ocupado_d;
   logic              fim_q, fim_d;

   logic              aceita_c;
   logic [W_DADO-1:0] comp_b_c;
   logic              maior_c, menor_c;

   assign aceita_c = pronto_q && bus.dado_valido;

   // Comparator B operand is selected purely by the current state.
   assign comp_b_c = (estado_q == COMPARA_MIN) ? minimo_q : maximo_q;

   comparador_8bit u_comparador (
      .a_i     (amostra_q),
      .b_i     (comp_b_c),
      .maior_o (maior_c),
      .menor_o (menor_c)
   );

   // Next-state and datapath updates.
   always_comb begin
      estado_d   = estado_q;
      maximo_d   = maximo_q;
      minimo_d   = minimo_q;
      amostra_d  = amostra_q;
      contagem_d = contagem_q;
      case (estado_q)
         INICIAL: begin
            if (bus.iniciar) begin
               contagem_d = '0;
               estado_d   = PRIMEIRO;
            end
         end
         PRIMEIRO: begin
            if (aceita_c) begin
               maximo_d   = bus.dado;
               minimo_d   = bus.dado;
               contagem_d = W_CONT'(1);
               estado_d   = ESPERA_DADO;
            end
         end
         ESPERA_DADO: begin
            if (aceita_c) begin
               amostra_d  = bus.dado;
               contagem_d = contagem_q + W_CONT'(1);
               estado_d   = COMPARA_MAX;
            end
         end
         COMPARA_MAX: begin
            if (maior_c) maximo_d = amostra_q;
            estado_d = COMPARA_MIN;
         end
         COMPARA_MIN: begin
            if (menor_c) minimo_d = amostra_q;
            estado_d = (contagem_q == W_CONT'(N_AMOSTRAS)) ? FIM : ESPERA_DADO;
         end
         FIM:     estado_d = INICIAL;
         default: estado_d = INICIAL;
      endcase
   end

   // Status flags follow the state being entered; fim trails the FIM state by one edge.
   assign pronto_d  = (estado_d == PRIMEIRO) || (estado_d == ESPERA_DADO);
   assign ocupado_d = (estado_d != INICIAL);
   assign fim_d     = (estado_q == FIM);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= INICIAL;
         maximo_q   <= '0;
         minimo_q   <= '0;
         amostra_q  <= '0;
         contagem_q <= '0;
         pronto_q   <= 1'b0;
         ocupado_q  <= 1'b0;
         fim_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         maximo_q   <= maximo_d;
         minimo_q   <= minimo_d;
         amostra_q  <= amostra_d;
         contagem_q <= contagem_d;
         pronto_q   <= pronto_d;
         ocupado_q  <= ocupado_d;
         fim_q      <= fim_d;
      end
   end

   assign bus.dado_pronto = pronto_q;
   assign bus.maximo      = maximo_q;
   assign bus.minimo      = minimo_q;
   assign bus.contagem    = contagem_q;
   assign bus.ocupado     = ocupado_q;
   assign bus.fim         = fim_q;
   assign bus.db_estado   = estado_q;

endmodule

// File: tb/tb_controle_maxmin.sv
// Scoreboard bench for controle_maxmin with N_AMOSTRAS=4: frames push expected
// results, a negedge monitor pops and checks them on every fim pulse.
module tb_controle_maxmin;
   import controle_maxmin_pkg::*;

   localparam int unsigned N = 4;

   typedef struct {
      logic [7:0] mx;
      logic [7:0] mn;
      logic [7:0] ct;
   } esp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   controle_maxmin_if bus();

   controle_maxmin #(.N_AMOSTRAS(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   esp_t fila[$];
   esp_t e;
   int   total      = 0;
   int   bad        = 0;
   int   fim_vistos = 0;
   int   desde_aceite = 99;
   logic fim_ant    = 1'b0;

   // Samples driven every cycle with dado_valido held high; only v36[2,3,6,9] land.
   logic [7:0] v36 [1:12] = '{8'hFF, 8'h30, 8'h50, 8'h00, 8'hFF, 8'h20,
                              8'hFF, 8'h00, 8'h60, 8'hFF, 8'h00, 8'hFF};

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      total++;
      if (atual !== esperado) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nome, atual, esperado);
      end
   endtask

   // Edges elapsed since the last accepted sample.
   always @(posedge clock or negedge reset) begin
      if (!reset)                                    desde_aceite <= 99;
      else if (bus.dado_pronto && bus.dado_valido)   desde_aceite <= 0;
      else if (desde_aceite < 99)                    desde_aceite <= desde_aceite + 1;
   end

   always @(negedge clock) begin
      if (bus.fim) begin
         fim_vistos++;
         chk("fim_pulso_unico", 32'(fim_ant), 32'd0);
         chk("fim_latencia", 32'(desde_aceite), 32'd3);
         if (fila.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fim_inesperado: got fim=1 with no frame pending, required fim=0");
         end else begin
            e = fila.pop_front();
            chk("maximo", 32'(bus.maximo), 32'(e.mx));
            chk("minimo", 32'(bus.minimo), 32'(e.mn));
            chk("contagem", 32'(bus.contagem), 32'(e.ct));
         end
      end
      fim_ant <= bus.fim;
   end

   task automatic checa_zeros(input string tag);
      chk({tag, "_maximo"},   32'(bus.maximo), 32'd0);
      chk({tag, "_minimo"},   32'(bus.minimo), 32'd0);
      chk({tag, "_contagem"}, 32'(bus.contagem), 32'd0);
      chk({tag, "_pronto"},   32'(bus.dado_pronto), 32'd0);
      chk({tag, "_ocupado"},  32'(bus.ocupado), 32'd0);
      chk({tag, "_fim"},      32'(bus.fim), 32'd0);
      chk({tag, "_estado"},   32'(bus.db_estado), 32'(INICIAL));
   endtask

   task automatic iniciar_quadro(input bit empilha, input logic [7:0] mx, input logic [7:0] mn);
      @(negedge clock);
      if (empilha) fila.push_back('{mx, mn, 8'(N)});
      bus.iniciar = 1'b1;
      @(negedge clock);
      bus.iniciar = 1'b0;
   endtask

   task automatic envia(input logic [7:0] v);
      int espera = 0;
      while (!bus.dado_pronto && espera < 20) begin
         @(negedge clock);
         espera++;
      end
      if (!bus.dado_pronto) begin
         total++;
         bad++;
         $display("FAIL timeout_pronto: got dado_pronto=0 after 20 cycles, required 1");
      end
      bus.dado        = v;
      bus.dado_valido = 1'b1;
      @(negedge clock);
      bus.dado_valido = 1'b0;
   endtask

   task automatic quadro(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, input logic [7:0] mx, input logic [7:0] mn);
      iniciar_quadro(1'b1, mx, mn);
      envia(s0);
      envia(s1);
      envia(s2);
      envia(s3);
      repeat (6) @(negedge clock);
      chk("maximo_retido", 32'(bus.maximo), 32'(mx));
      chk("contagem_retida", 32'(bus.contagem), 32'(N));
      chk("ocupado_fim", 32'(bus.ocupado), 32'd0);
   endtask

   initial begin
      bus.iniciar     = 1'b0;
      bus.dado        = 8'h00;
      bus.dado_valido = 1'b0;
      repeat (2) @(negedge clock);
      checa_zeros("reset");
      reset = 1'b1;

      quadro(8'h10, 8'h80, 8'h05, 8'h40, 8'h80, 8'h05);
      quadro(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
      quadro(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);

      // Valid held high, iniciar re-pulsed mid-frame.
      @(negedge clock);
      fila.push_back('{8'h60, 8'h20, 8'(N)});
      for (int k = 1; k <= 12; k++) begin
         bus.dado        = v36[k];
         bus.dado_valido = 1'b1;
         bus.iniciar     = (k == 1 || k == 4 || k == 5);
         @(negedge clock);
      end
      bus.dado_valido = 1'b0;
      bus.iniciar     = 1'b0;
      repeat (4) @(negedge clock);

      // Reset during COMPARA_MAX of the third sample.
      iniciar_quadro(1'b0, 8'h00, 8'h00);
      envia(8'h10);
      envia(8'h20);
      envia(8'h30);
      chk("estado_antes_reset", 32'(bus.db_estado), 32'(COMPARA_MAX));
      reset = 1'b0;
      #1;
      checa_zeros("abort");
      repeat (2) @(negedge clock);
      chk("abort_fim", 32'(bus.fim), 32'd0);
      reset = 1'b1;
      repeat (6) @(negedge clock);
      chk("abort_sem_fim", 32'(fim_vistos), 32'd4);

      quadro(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h01);

      repeat (4) @(negedge clock);
      chk("fila_vazia", 32'(fila.size()), 32'd0);
      chk("numero_fim", 32'(fim_vistos), 32'd5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controle_maxmin.md
CONTROLE_MAXMIN -- requirements
Module: controle_maxmin

Interface
REQ-001 Parameter: N_AMOSTRAS, default 8, number of samples per frame; legal range 2..255.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 iniciar  in  1  start-of-frame request; sampled on the rising edge.
REQ-005 dado  in  8  unsigned sample.
REQ-006 dado_valido  in  1  sample present on dado.
REQ-007 dado_pronto  out  1  block accepts a sample this cycle.
REQ-008 maximo  out  8  running/final maximum of the frame.
REQ-009 minimo  out  8  running/final minimum of the frame.
REQ-010 contagem  out  8  number of samples accepted in the current frame.
REQ-011 ocupado  out  1  frame in progress.
REQ-012 fim  out  1  one-cycle pulse when the frame result is final.
REQ-013 db_estado  out  3  current FSM state code, for debug.

Function
REQ-014 A sample SHALL be accepted only in a cycle where dado_pronto=1 and dado_valido=1; dado_valido with dado_pronto=0 SHALL be ignored, with no buffering.
REQ-015 The FSM SHALL have these states and codes: INICIAL=0, PRIMEIRO=1, ESPERA_DADO=2, COMPARA_MAX=3, COMPARA_MIN=4, FIM=5.
REQ-016 INICIAL: dado_pronto=0, ocupado=0; iniciar=1 -> PRIMEIRO, contagem cleared to 0.
REQ-017 PRIMEIRO: dado_pronto=1; on accept, maximo=minimo=dado, contagem=1 -> ESPERA_DADO.
REQ-018 ESPERA_DADO: dado_pronto=1; on accept, dado latched into internal register amostra, contagem+1 -> COMPARA_MAX.
REQ-019 COMPARA_MAX: the single comparator SHALL be driven with A=amostra, B=maximo; if "maior", maximo<=amostra; -> COMPARA_MIN.
REQ-020 COMPARA_MIN: the same comparator SHALL be driven with A=amostra, B=minimo; if "menor", minimo<=amostra; if contagem==N_AMOSTRAS -> FIM, else -> ESPERA_DADO.
REQ-021 FIM: fim=1 for exactly one cycle -> INICIAL.
REQ-022 Updates SHALL be strict: an equal sample changes neither maximo nor minimo.
REQ-023 ocupado SHALL be 1 in every state except INICIAL.
REQ-024 Throughput SHALL be one sample per 3 cycles after the first sample.
REQ-025 Latency: for the last sample accepted at edge t, fim=1 in the cycle following edge t+3.
REQ-026 iniciar SHALL be ignored while ocupado=1.
REQ-027 maximo, minimo and contagem SHALL hold their final values after fim until the next frame overwrites them.
REQ-028 The comparator mux select SHALL be a pure decode of the state; no other arithmetic beyond the 8-bit contagem increment is required.

Reset
REQ-029 reset=0 SHALL immediately force state INICIAL and maximo=minimo=contagem=0x00, with dado_pronto=ocupado=fim=0 and db_estado=0.
REQ-030 Reset during a frame SHALL abort it with no fim pulse; the next iniciar after reset release SHALL start a clean frame.

Structure
REQ-031 State codes and the N_AMOSTRAS default SHALL live in a shared constants include/package used by RTL and bench.
REQ-032 The design SHALL contain exactly one comparador_8bit instance, time-shared between the max and min phases; it is the only sub-module.

Verification
REQ-033 N=4; reset, then iniciar, then samples 0x10,0x80,0x05,0x40 -> maximo=0x80, minimo=0x05, contagem=4, single fim pulse 3 cycles after the 4th accept.
REQ-034 N=4; samples 0x7F x4 -> maximo=minimo=0x7F, with no update in any comparison cycle.
REQ-035 N=4; samples 0xFF,0x00,0xFF,0x00 -> maximo=0xFF, minimo=0x00, confirming both boundary values.
REQ-036 dado_valido held at 1 throughout, with iniciar pulsed mid-frame -> only samples presented while dado_pronto=1 are counted, the frame is not restarted, and contagem reaches 4.
REQ-037 reset pulsed while in COMPARA_MAX of the 3rd sample -> all outputs 0 and no fim; the following frame 0x01,0x02,0x03,0x04 gives maximo=0x04, minimo=0x01.
